noc_tok_lnk_tx: RTL and testbench
=================================

Name: noc_tok_lnk_tx

Overview:
Token-network link transmitter (endpoint egress side). It collects token pulses from NUM_SRC local producers and batches them in per-source saturating counters. It picks among pending sources round-robin and emits single-flit token packets on a data/head/tail/vld/rdy link toward the h-block token router ingress. It sits in each client partition between local token producers and the lnk_cross_*_tok_N ingress of the NoC token fabric.

Parameters:
NUM_SRC, 8, number of local token sources (>=2)
DATA_W, 42, link flit data width (42 for tok_0 links, 32 for tok_1 links)
ROUTE_W, 16, per-source route/destination field width
CNT_W, 4, per-source pending counter width and flit count field width
SRC_W, $clog2(NUM_SRC), source id field width (derived, not overridable)

Ports:
i_noc_clk  in  1  NoC clock; all logic on rising edge
i_noc_rst_n  in  1  asynchronous active-low reset
scan_en  in  1  DFT scan enable; no functional effect
i_tok_pulse  in  NUM_SRC  one-cycle token pulse per source
i_route_cfg  in  NUM_SRC*ROUTE_W  quasi-static route per source; slice s is source s
o_dp_tok_data  out  DATA_W  flit payload
o_dp_tok_head  out  1  head flag
o_dp_tok_tail  out  1  tail flag
o_dp_tok_vld  out  1  flit valid
i_dp_tok_rdy  in  1  downstream ready
o_tok_overflow  out  NUM_SRC  sticky per-source counter saturation flag

Behaviour:
- Reset: the clock is i_noc_clk and the reset is i_noc_rst_n, asynchronous and active-low. Reset clears all counters, the output register (vld=0, data=0, head=0, tail=0) and o_tok_overflow. The RR pointer resets to NUM_SRC-1, so source 0 has first priority. Outputs clear immediately on reset assertion, without waiting for a clock edge.
- Counters: cnt[s] increments on i_tok_pulse[s] and saturates at 2^CNT_W-1.
  - A pulse arriving while the counter is already saturated sets o_tok_overflow[s]. The flag stays set until reset.
- Output register: a single flit stage. It loads when (!vld) or (vld && rdy).
  - While vld=1 and rdy=0, data, head, tail and vld hold stable.
- Arbitration: combinational round-robin over sources with cnt!=0, searching from ptr+1 with wrap. Evaluated only on cycles where the output register loads. On a grant to source g:
  - The register loads the flit for g and vld=1.
  - ptr becomes g.
  - cnt[g] becomes 0, or 1 if i_tok_pulse[g] is high that same cycle. No pulse is lost.
- No pending source on a load cycle: vld goes to 0.
- Flit format: head=1, tail=1 on every flit.
  - data[ROUTE_W-1:0] = i_route_cfg slice g
  - data[ROUTE_W+SRC_W-1:ROUTE_W] = g
  - data[ROUTE_W+SRC_W+CNT_W-1:ROUTE_W+SRC_W] = batched count (1..2^CNT_W-1)
  - all remaining upper bits = 0
  - Requires ROUTE_W+SRC_W+CNT_W <= DATA_W; elaboration error otherwise.
- Latency: pulse at cycle t, counter nonzero at t+1, flit vld at t+2 (output empty or draining). Throughput is 1 flit/cycle with rdy=1.
- Fairness: with all sources continuously pending and rdy=1, grants rotate 0,1,...,NUM_SRC-1,0,...
- i_route_cfg is sampled at load time only. Changes have no effect on a flit already held.
- Rdy may toggle freely. vld never depends combinationally on rdy in the same cycle's register output.

Optional Feature:
NOC_TOK_LNK_TX_PERF_CNT_EN:
- Defined: adds output o_perf_flit_cnt (32 bits), incremented on each vld&&rdy cycle. It wraps at 2^32 and resets to 0.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Single pulse: i_tok_pulse[2] at t, route_cfg[2]=0x1234, rdy=1 -> at t+2: vld=1, head=tail=1, data route=0x1234, src=2, count=1. vld=0 at t+3.
- Backpressure batching: rdy=0 from reset, pulse src0 once -> flit count=1 held stable. Then 5 more pulses on src0, then rdy=1 -> first flit accepted, next flit src=0 count=5.
- Fairness: all 8 sources pulse in the same cycle, rdy=1 -> 8 consecutive flits with src 0..7, each count=1, then vld=0.
- Saturation: rdy=0, 20 pulses on src1 -> held flit count=1, counter 15, o_tok_overflow[1]=1. With rdy=1: next flit count=15, and the overflow flag stays 1.
- Coincident pulse: pulse on src3 in the same cycle src3 is granted -> cnt[3]=1 afterwards, and a second src3 flit with count=1 follows.
- Reset mid-operation: assert i_noc_rst_n=0 while vld=1 and rdy=0 -> vld, data and overflow go to 0 immediately. After release, no flit is emitted until a new pulse.

Source files
------------

// File: rtl/noc_tok_lnk_tx.sv
// noc_tok_lnk_tx: batches local token pulses per source and emits round-robin single-flit token packets.
// Optional NOC_TOK_LNK_TX_PERF_CNT_EN adds o_perf_flit_cnt, a count of accepted flits.
module noc_tok_lnk_tx #(
   parameter int NUM_SRC = 8,
   parameter int DATA_W  = 42,
   parameter int ROUTE_W = 16,
   parameter int CNT_W   = 4,
   localparam int SRC_W  = $clog2(NUM_SRC)
) (
   input  logic                       i_noc_clk,
   input  logic                       i_noc_rst_n,
   input  logic                       scan_en,
   input  logic [NUM_SRC-1:0]         i_tok_pulse,
   input  logic [NUM_SRC*ROUTE_W-1:0] i_route_cfg,
   output logic [DATA_W-1:0]          o_dp_tok_data,
   output logic                       o_dp_tok_head,
   output logic                       o_dp_tok_tail,
   output logic                       o_dp_tok_vld,
   input  logic                       i_dp_tok_rdy,
`ifdef NOC_TOK_LNK_TX_PERF_CNT_EN
   output logic [31:0]                o_perf_flit_cnt,
`endif
   output logic [NUM_SRC-1:0]         o_tok_overflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (ROUTE_W + SRC_W + CNT_W > DATA_W) begin : g_width_chk
      $error("noc_tok_lnk_tx: flit fields exceed DATA_W");
   end

   logic [CNT_W-1:0] cnt [NUM_SRC];
   logic [SRC_W-1:0] ptr, gnt, idx;
   logic             gnt_vld, load;
   logic [DATA_W-1:0] flit;
   logic             unused_scan;

   assign unused_scan = scan_en;
   assign load = !o_dp_tok_vld || i_dp_tok_rdy;
   assign flit = DATA_W'({cnt[gnt], gnt, i_route_cfg[int'(gnt)*ROUTE_W +: ROUTE_W]});

   // first pending source after ptr, wrapping
   always_comb begin
      gnt = ptr;
      gnt_vld = 1'b0;
      idx = '0;
      for (int i = 1; i <= NUM_SRC; i++) begin
         idx = SRC_W'((int'(ptr) + i) % NUM_SRC);
         if (!gnt_vld && cnt[idx] != '0) begin
            gnt_vld = 1'b1;
            gnt = idx;
         end
      end
   end

   always_ff @(posedge i_noc_clk or negedge i_noc_rst_n) begin
      if (!i_noc_rst_n) begin
         for (int s = 0; s < NUM_SRC; s++) cnt[s] <= '0;
         o_tok_overflow <= '0;
      end else begin
         for (int s = 0; s < NUM_SRC; s++) begin
            if (load && gnt_vld && gnt == SRC_W'(s))
               cnt[s] <= i_tok_pulse[s] ? CNT_W'(1) : '0;
            else if (i_tok_pulse[s] && cnt[s] != CNT_MAX)
               cnt[s] <= cnt[s] + 1'b1;
            else if (i_tok_pulse[s])
               o_tok_overflow[s] <= 1'b1;
         end
      end
   end

   always_ff @(posedge i_noc_clk or negedge i_noc_rst_n) begin
      if (!i_noc_rst_n) begin
         ptr <= SRC_W'(NUM_SRC - 1);
         o_dp_tok_vld <= 1'b0;
         o_dp_tok_head <= 1'b0;
         o_dp_tok_tail <= 1'b0;
         o_dp_tok_data <= '0;
      end else if (load) begin
         ptr <= gnt_vld ? gnt : ptr;
         o_dp_tok_vld <= gnt_vld;
         o_dp_tok_head <= gnt_vld;
         o_dp_tok_tail <= gnt_vld;
         o_dp_tok_data <= gnt_vld ? flit : '0;
      end
   end

`ifdef NOC_TOK_LNK_TX_PERF_CNT_EN
   always_ff @(posedge i_noc_clk or negedge i_noc_rst_n) begin
      if (!i_noc_rst_n) o_perf_flit_cnt <= '0;
      else if (o_dp_tok_vld && i_dp_tok_rdy) o_perf_flit_cnt <= o_perf_flit_cnt + 1'b1;
   end
`endif

endmodule

// File: tb/tb_noc_tok_lnk_tx.sv
// tb_noc_tok_lnk_tx: directed vector table plus hand sequences for noc_tok_lnk_tx.
module tb_noc_tok_lnk_tx;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         scan_en = 1'b0;
   logic [7:0]   pulse = '0;
   logic [127:0] route_cfg;
   logic [41:0]  data;
   logic         head, tail, vld;
   logic         rdy = 1'b1;
   logic [7:0]   ovf;
`ifdef NOC_TOK_LNK_TX_PERF_CNT_EN
   logic [31:0]  perf;
`endif
   int checks = 0;
   int errors = 0;

   noc_tok_lnk_tx dut (
      .i_noc_clk(clk),
      .i_noc_rst_n(rst_n),
      .scan_en(scan_en),
      .i_tok_pulse(pulse),
      .i_route_cfg(route_cfg),
      .o_dp_tok_data(data),
      .o_dp_tok_head(head),
      .o_dp_tok_tail(tail),
      .o_dp_tok_vld(vld),
      .i_dp_tok_rdy(rdy),
`ifdef NOC_TOK_LNK_TX_PERF_CNT_EN
      .o_perf_flit_cnt(perf),
`endif
      .o_tok_overflow(ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] pulse;
      logic       rdy;
      logic       vld;
      int         src;
      int         cnt;
   } vec_t;

   vec_t vt[13];

   function automatic logic [15:0] route_of(int s);
      return s == 2 ? 16'h1234 : 16'h0F00 + 16'(s);
   endfunction

   function automatic logic [41:0] exp_data(int g, int c);
      return (42'(c) << 19) | (42'(g) << 16) | 42'(route_of(g));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_flit(string name, logic ev, int g, int c);
      chk({name, ".vld"}, 64'(vld), 64'(ev));
      if (ev) begin
         chk({name, ".data"}, 64'(data), 64'(exp_data(g, c)));
         chk({name, ".head"}, 64'(head), 64'd1);
         chk({name, ".tail"}, 64'(tail), 64'd1);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      pulse = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      for (int s = 0; s < 8; s++) route_cfg[s*16 +: 16] = route_of(s);
      // fairness burst then a single pulse on src2
      vt[0] = '{8'hFF, 1'b1, 1'b0, 0, 0};
      for (int i = 0; i < 8; i++) vt[1+i] = '{8'h00, 1'b1, 1'b1, i, 1};
      vt[9]  = '{8'h00, 1'b1, 1'b0, 0, 0};
      vt[10] = '{8'h04, 1'b1, 1'b0, 0, 0};
      vt[11] = '{8'h00, 1'b1, 1'b1, 2, 1};
      vt[12] = '{8'h00, 1'b1, 1'b0, 0, 0};

      #2;
      chk("rst.vld", 64'(vld), 64'd0);
      chk("rst.data", 64'(data), 64'd0);
      chk("rst.head", 64'(head), 64'd0);
      chk("rst.ovf", 64'(ovf), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;

      for (int i = 0; i < 13; i++) begin
         pulse = vt[i].pulse;
         rdy = vt[i].rdy;
         tick();
         chk_flit($sformatf("vec%0d", i), vt[i].vld, vt[i].src, vt[i].cnt);
      end
      pulse = '0;
      chk("vec.ovf", 64'(ovf), 64'd0);

      // backpressure batching
      rdy = 1'b0;
      do_reset();
      pulse = 8'h01;
      tick();
      pulse = '0;
      tick();
      chk_flit("bp.first", 1'b1, 0, 1);
      for (int i = 0; i < 5; i++) begin
         pulse = 8'h01;
         tick();
         chk_flit($sformatf("bp.hold%0d", i), 1'b1, 0, 1);
      end
      pulse = '0;
      rdy = 1'b1;
      tick();
      chk_flit("bp.batch", 1'b1, 0, 5);
      tick();
      chk_flit("bp.idle", 1'b0, 0, 0);

      // saturation and sticky overflow
      rdy = 1'b0;
      do_reset();
      for (int i = 0; i < 20; i++) begin
         pulse = 8'h02;
         tick();
      end
      pulse = '0;
      chk_flit("sat.held", 1'b1, 1, 1);
      chk("sat.ovf", 64'(ovf), 64'h02);
      rdy = 1'b1;
      tick();
      chk_flit("sat.batch", 1'b1, 1, 15);
      chk("sat.ovf2", 64'(ovf), 64'h02);
      tick();
      chk_flit("sat.idle", 1'b0, 0, 0);
      chk("sat.ovf3", 64'(ovf), 64'h02);

      // pulse coincident with grant
      rdy = 1'b1;
      do_reset();
      pulse = 8'h08;
      tick();
      tick();
      chk_flit("coin.first", 1'b1, 3, 1);
      pulse = '0;
      tick();
      chk_flit("coin.second", 1'b1, 3, 1);
      tick();
      chk_flit("coin.idle", 1'b0, 0, 0);

      // asynchronous reset while a flit is held
      rdy = 1'b0;
      do_reset();
      for (int i = 0; i < 18; i++) begin
         pulse = 8'h02;
         tick();
      end
      pulse = '0;
      chk_flit("arst.pre", 1'b1, 1, 1);
      chk("arst.pre_ovf", 64'(ovf), 64'h02);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.vld", 64'(vld), 64'd0);
      chk("arst.data", 64'(data), 64'd0);
      chk("arst.ovf", 64'(ovf), 64'd0);
      tick();
      rst_n = 1'b1;
      rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_flit($sformatf("arst.quiet%0d", i), 1'b0, 0, 0);
      end
      pulse = 8'h10;
      tick();
      pulse = '0;
      tick();
      chk_flit("arst.new", 1'b1, 4, 1);
      tick();
      chk_flit("arst.idle", 1'b0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
